ram_fifo_ctrl: RTL and testbench
================================

Name: ram_fifo_ctrl

Overview:
- Valid/ready FIFO controller that sits directly upstream of the single-port RAM block.
- Drives the RAM's Addr/Write/Input ports and consumes its Output, turning the raw RAM into a streaming FIFO of depth 2**ADDR_WIDTH.
- Adds one output holding register, so producer and consumer never see RAM timing.

Parameters:
- DATA_WIDTH, 8, width of each FIFO word; matches the RAM's DATA_WIDTH.
- ADDR_WIDTH, 8, RAM address width; RAM depth DEPTH = 2**ADDR_WIDTH.

Ports:
- Clk  input  1  single clock; all state changes on the rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- PushValid  input  1  producer offers PushData.
- PushReady  output  1  controller accepts the push this cycle.
- PushData  input  DATA_WIDTH  word to enqueue.
- PopValid  output  1  PopData holds the head word.
- PopReady  input  1  consumer takes the head word.
- PopData  output  DATA_WIDTH  head word, registered.
- Count  output  ADDR_WIDTH+2  total words held (RAM + in-flight read + output register).
- Full  output  1  RAM region full (mem_count == DEPTH).
- Empty  output  1  Count == 0.
- RamAddr  output  ADDR_WIDTH  to RAM Addr.
- RamWrite  output  1  to RAM Write.
- RamInput  output  DATA_WIDTH  to RAM Input; always equals PushData.
- RamOutput  input  DATA_WIDTH  from RAM Output; valid the cycle after a read address is presented.

Behaviour:
- RAM contract:
  - Write commits at the edge when RamWrite=1.
  - Read: address presented in cycle N, data valid on RamOutput throughout cycle N+1.
- Internal state: wr_ptr, rd_ptr (ADDR_WIDTH, wrap naturally at DEPTH); mem_count (0..DEPTH); rd_pending; PopValid register.
- Reset (async, Reset_n=0):
  - Pointers, mem_count, rd_pending, PopValid and PopData are cleared to 0.
  - Count=0, Full=0, Empty=1, RamWrite=0, PushReady=0.
  - RAM contents are not cleared; stale data is unreachable.
- Handshake completion:
  - Pop completes when PopValid && PopReady.
  - Push completes when PushValid && PushReady.
- Each cycle the RAM port is used for exactly one of IDLE, READ or WRITE.
- READ issue condition: !rd_pending && mem_count>0 && (!PopValid || pop this cycle). On issue:
  - RamAddr=rd_ptr, RamWrite=0.
  - At the edge: rd_ptr+1, mem_count-1, rd_pending=1.
- rd_pending cycle: at the edge, PopData<=RamOutput, PopValid<=1, rd_pending<=0. PopValid is guaranteed 0 in this cycle.
- WRITE:
  - PushReady = !Full && !read_issue && Reset_n.
  - On push: RamAddr=wr_ptr, RamWrite=1; at the edge wr_ptr+1, mem_count+1.
- Priority: READ beats WRITE. A push offered in a read-issue cycle sees PushReady=0 and stalls one cycle.
- Pop without a refill: PopValid clears at the edge.
- Simultaneous push and pop in the same cycle is allowed when no read is issued; the count is unchanged in net.
- Latency:
  - A push accepted in cycle N into an empty FIFO gives PopValid=1 in cycle N+3.
  - No bypass path.
- Throughput: sustained pop rate is 1 word per 2 cycles. Writes fill the rd_pending cycles, so push throughput is ≥1 per 2 cycles under a full-rate pop.
- Capacity: DEPTH+1 words total (DEPTH in RAM + 1 in the output register).
- Boundary conditions:
  - Push while Full: ignored, PushReady=0.
  - Pop while !PopValid: ignored.
  - Pointer wrap DEPTH-1 → 0 is silent.
  - Count never exceeds DEPTH+1.
- Reset asserted mid-read: the pending data is discarded.
- Width: Count = mem_count + rd_pending + PopValid, computed at ADDR_WIDTH+2 bits with no overflow.

Decomposition:
- Package ram_fifo_pkg:
  - Enum port_op_t {OP_IDLE, OP_READ, OP_WRITE}.
  - Localparam function for DEPTH.
  - Count width constant.
- One sub-module, ram_fifo_ptr: ADDR_WIDTH wrap-around pointer with enable, async active-low reset. Instantiated twice (rd/wr).
- RAM instantiation belongs in a thin top wrapper, ram_fifo, not in this block.

Test Plan (DATA_WIDTH=8, ADDR_WIDTH=4, DEPTH=16):
- Reset, push 42 in cycle N, PopReady=1 -> PopValid=1 in cycle N+3 with PopData=42; then Empty=1, Count=0.
- PopReady=0, push values 0..16 continuously -> all 17 accepted; Count=17, Full=1; a further push of 99 sees PushReady=0 and is never stored.
- From that full state, PopReady=1 -> pops 0..16 in order, one every 2 cycles; ends with Empty=1, Count=0, Full=0.
- Stream 40 values (i*3 mod 256) with pseudo-random PushValid/PopReady stalls -> all 40 popped in order across both pointer wraps; no loss or duplication.
- Contention: PopValid=1 popped while PushValid=1 and mem_count>0 -> PushReady=0 that cycle and RamWrite=0; the push is accepted the next cycle with the correct value.
- With 5 words held, drop Reset_n mid-cycle during rd_pending -> PopValid, Count and Full go 0 without waiting for a clock edge, Empty=1; after release, push 7 -> first pop returns 7.

Source files
------------

// File: rtl/ram_fifo_pkg.sv
// rtl/ram_fifo_pkg.sv - shared types and sizing helpers for the RAM-backed FIFO controller
package ram_fifo_pkg;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } port_op_t;

    // Count spans RAM words plus the in-flight read and the output register.
    localparam int COUNT_EXTRA_BITS = 2;

    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

    function automatic int count_width(input int addr_width);
        return addr_width + COUNT_EXTRA_BITS;
    endfunction

endpackage

// File: rtl/ram_fifo_ptr.sv
// rtl/ram_fifo_ptr.sv - wrap-around RAM address pointer with increment enable
module ram_fifo_ptr #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    output logic [ADDR_WIDTH-1:0] ptr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= ptr + ADDR_WIDTH'(1);
        end
    end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// rtl/ram_fifo_ctrl.sv - valid/ready FIFO controller driving a single-port synchronous RAM
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                                Clk,
    input  logic                                Reset_n,
    input  logic                                PushValid,
    output logic                                PushReady,
    input  logic [DATA_WIDTH-1:0]               PushData,
    output logic                                PopValid,
    input  logic                                PopReady,
    output logic [DATA_WIDTH-1:0]               PopData,
    output logic [count_width(ADDR_WIDTH)-1:0]  Count,
    output logic                                Full,
    output logic                                Empty,
    output logic [ADDR_WIDTH-1:0]               RamAddr,
    output logic                                RamWrite,
    output logic [DATA_WIDTH-1:0]               RamInput,
    input  logic [DATA_WIDTH-1:0]               RamOutput
);

    localparam int MEM_W = ADDR_WIDTH + 1;
    localparam int CNT_W = count_width(ADDR_WIDTH);
    localparam logic [MEM_W-1:0] MEM_FULL = MEM_W'(depth_of(ADDR_WIDTH));

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [MEM_W-1:0]      mem_count;
    logic                  rd_pending;
    logic                  pop;
    logic                  push;
    logic                  read_issue;
    port_op_t              port_op;

    assign pop  = PopValid && PopReady;
    // A read may only start when the output register will be free by the time data lands.
    assign read_issue = !rd_pending && (mem_count != '0) && (!PopValid || pop);
    assign PushReady  = !Full && !read_issue && Reset_n;
    assign push       = PushValid && PushReady;

    always_comb begin
        port_op = OP_IDLE;
        if (read_issue) begin
            port_op = OP_READ;
        end else if (push) begin
            port_op = OP_WRITE;
        end
    end

    assign RamWrite = (port_op == OP_WRITE);
    assign RamAddr  = (port_op == OP_READ) ? rd_ptr : wr_ptr;
    assign RamInput = PushData;

    ram_fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
        .clk   (Clk),
        .rst_n (Reset_n),
        .en    (read_issue),
        .ptr   (rd_ptr)
    );

    ram_fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
        .clk   (Clk),
        .rst_n (Reset_n),
        .en    (push),
        .ptr   (wr_ptr)
    );

    // Read and write are exclusive on the port, so mem_count moves by at most one.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mem_count <= '0;
        end else if (read_issue) begin
            mem_count <= mem_count - MEM_W'(1);
        end else if (push) begin
            mem_count <= mem_count + MEM_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_pending <= 1'b0;
            PopValid   <= 1'b0;
            PopData    <= '0;
        end else begin
            rd_pending <= read_issue;
            if (rd_pending) begin
                PopValid <= 1'b1;
                PopData  <= RamOutput;
            end else if (pop) begin
                PopValid <= 1'b0;
            end
        end
    end

    assign Full  = (mem_count == MEM_FULL);
    assign Count = CNT_W'(mem_count) + CNT_W'(rd_pending) + CNT_W'(PopValid);
    assign Empty = (Count == '0);

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb/tb_ram_fifo_ctrl.sv - randomized self-checking bench for ram_fifo_ctrl with a queue reference model
module tb_ram_fifo_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic          PushValid;
    logic          PushReady;
    logic [DW-1:0] PushData;
    logic          PopValid;
    logic          PopReady;
    logic [DW-1:0] PopData;
    logic [AW+1:0] Count;
    logic          Full;
    logic          Empty;
    logic [AW-1:0] RamAddr;
    logic          RamWrite;
    logic [DW-1:0] RamInput;
    logic [DW-1:0] RamOutput;

    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] model [$];

    int passed = 0;
    int total  = 0;

    // Per-cycle observations captured by advance()
    bit            s_pf, s_qf, s_pv, s_pr, s_full, s_empty, s_rw;
    logic [DW-1:0] s_got, s_exp;
    int            s_cnt, s_exp_cnt;

    ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .PushValid (PushValid),
        .PushReady (PushReady),
        .PushData  (PushData),
        .PopValid  (PopValid),
        .PopReady  (PopReady),
        .PopData   (PopData),
        .Count     (Count),
        .Full      (Full),
        .Empty     (Empty),
        .RamAddr   (RamAddr),
        .RamWrite  (RamWrite),
        .RamInput  (RamInput),
        .RamOutput (RamOutput)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (RamWrite) ram[RamAddr] <= RamInput;
        RamOutput <= ram[RamAddr];
    end

    task automatic advance();
        @(negedge Clk);
        s_pv      = PopValid;
        s_pr      = PushReady;
        s_full    = Full;
        s_empty   = Empty;
        s_rw      = RamWrite;
        s_cnt     = int'(Count);
        s_exp_cnt = model.size();
        s_pf      = PushValid && PushReady;
        s_qf      = PopValid && PopReady;
        s_got     = PopData;
        s_exp     = 'x;
        if (s_qf && model.size() > 0) s_exp = model.pop_front();
        if (s_pf) model.push_back(PushData);
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; PushValid = 1'b1; PushData = 8'h55; PopReady = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        total++; if (Count !== 6'd0) $display("FAIL reset_count got=%0d exp=0", Count); else passed++;
        total++; if (Empty !== 1'b1 || Full !== 1'b0) $display("FAIL reset_flags empty=%b full=%b exp 1/0", Empty, Full); else passed++;
        total++; if (PushReady !== 1'b0 || RamWrite !== 1'b0) $display("FAIL reset_port pushready=%b ramwrite=%b exp 0/0", PushReady, RamWrite); else passed++;
        total++; if (PopValid !== 1'b0 || PopData !== 8'd0) $display("FAIL reset_pop popvalid=%b popdata=%0d exp 0/0", PopValid, PopData); else passed++;
        @(posedge Clk); #1;
        Reset_n = 1'b1; PushValid = 1'b0;
        model.delete();
    endtask

    task automatic test_latency();
        bit pv_seq [3];
        PopReady = 1'b1; PushValid = 1'b1; PushData = 8'd42;
        for (int k = 0; k < 20; k++) begin
            advance();
            if (s_pf) break;
        end
        total++; if (!s_pf) $display("FAIL latency_push_accept got=0 exp=1"); else passed++;
        PushValid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            advance();
            pv_seq[k] = s_pv;
        end
        total++; if (pv_seq[0] !== 1'b0 || pv_seq[1] !== 1'b0 || pv_seq[2] !== 1'b1)
            $display("FAIL latency_popvalid got=%b%b%b exp=001", pv_seq[0], pv_seq[1], pv_seq[2]); else passed++;
        total++; if (s_got !== 8'd42) $display("FAIL latency_data got=%0d exp=42", s_got); else passed++;
        advance();
        total++; if (s_empty !== 1'b1 || s_cnt != 0) $display("FAIL latency_after empty=%b count=%0d exp 1/0", s_empty, s_cnt); else passed++;
    endtask

    task automatic test_fill();
        int i = 0;
        PopReady = 1'b0;
        for (int k = 0; k < 200 && i <= DEPTH; k++) begin
            PushValid = 1'b1; PushData = DW'(i);
            advance();
            if (s_pf) i++;
        end
        total++; if (i != DEPTH + 1) $display("FAIL fill_accepted got=%0d exp=%0d", i, DEPTH + 1); else passed++;
        PushData = 8'd99;
        for (int k = 0; k < 3; k++) begin
            advance();
            total++; if (s_pr !== 1'b0 || s_pf) $display("FAIL fill_overflow_ready got=%b exp=0", s_pr); else passed++;
        end
        total++; if (s_cnt != DEPTH + 1 || s_full !== 1'b1) $display("FAIL fill_state count=%0d full=%b exp %0d/1", s_cnt, s_full, DEPTH + 1); else passed++;
        PushValid = 1'b0;
    endtask

    task automatic test_drain();
        int n = 0;
        int last = -1;
        int cyc = 0;
        PopReady = 1'b1;
        for (int k = 0; k < 100 && n <= DEPTH; k++) begin
            advance();
            cyc++;
            if (s_qf) begin
                total++; if (s_got !== DW'(n) || s_got !== s_exp) $display("FAIL drain_data got=%0d exp=%0d", s_got, n); else passed++;
                if (last >= 0) begin
                    total++; if (cyc - last != 2) $display("FAIL drain_spacing got=%0d exp=2", cyc - last); else passed++;
                end
                last = cyc;
                n++;
            end
        end
        total++; if (n != DEPTH + 1) $display("FAIL drain_count got=%0d exp=%0d", n, DEPTH + 1); else passed++;
        advance();
        total++; if (s_empty !== 1'b1 || s_cnt != 0 || s_full !== 1'b0) $display("FAIL drain_final empty=%b count=%0d full=%b exp 1/0/0", s_empty, s_cnt, s_full); else passed++;
    endtask

    task automatic test_random_stream();
        int nxt = 0;
        int got_n = 0;
        int errs = 0;
        for (int k = 0; k < 2000 && got_n < 40; k++) begin
            PushValid = (nxt < 40) && ($urandom_range(0, 9) < 7);
            PushData  = DW'(nxt * 3);
            PopReady  = ($urandom_range(0, 9) < 6);
            advance();
            if (s_pf) nxt++;
            if (s_cnt != s_exp_cnt || s_empty !== (s_exp_cnt == 0) || s_cnt > DEPTH + 1) begin
                errs++;
                if (errs < 4) $display("FAIL stream_count got=%0d exp=%0d empty=%b", s_cnt, s_exp_cnt, s_empty);
            end
            if (s_qf) begin
                total++;
                if (s_got !== s_exp || s_got !== DW'(got_n * 3)) $display("FAIL stream_data idx=%0d got=%0d exp=%0d", got_n, s_got, DW'(got_n * 3));
                else passed++;
                got_n++;
            end
        end
        total++; if (errs != 0) $display("FAIL stream_count_errors got=%0d exp=0", errs); else passed++;
        total++; if (got_n != 40) $display("FAIL stream_total got=%0d exp=40", got_n); else passed++;
        PushValid = 1'b0; PopReady = 1'b0;
    endtask

    task automatic test_contention();
        logic [DW-1:0] exp_list [4];
        int n = 0;
        exp_list = '{8'd10, 8'd11, 8'd12, 8'd77};
        PopReady = 1'b0;
        for (int v = 10; v <= 12; v++) begin
            PushValid = 1'b1; PushData = DW'(v);
            for (int k = 0; k < 10; k++) begin
                advance();
                if (s_pf) break;
            end
        end
        PushValid = 1'b0;
        repeat (4) advance();
        PopReady = 1'b1; PushValid = 1'b1; PushData = 8'd77;
        advance();
        total++; if (!s_qf || s_pr !== 1'b0 || s_rw !== 1'b0) $display("FAIL contention_stall pop=%b pushready=%b ramwrite=%b exp 1/0/0", s_qf, s_pr, s_rw); else passed++;
        if (s_qf) n++;
        PopReady = 1'b0;
        advance();
        total++; if (!s_pf || s_rw !== 1'b1) $display("FAIL contention_accept push=%b ramwrite=%b exp 1/1", s_pf, s_rw); else passed++;
        PushValid = 1'b0; PopReady = 1'b1;
        for (int k = 0; k < 30 && n < 4; k++) begin
            advance();
            if (s_qf) begin
                total++; if (s_got !== exp_list[n] || s_got !== s_exp) $display("FAIL contention_data got=%0d exp=%0d", s_got, exp_list[n]); else passed++;
                n++;
            end
        end
        total++; if (n != 4) $display("FAIL contention_pops got=%0d exp=4", n); else passed++;
        PopReady = 1'b0;
    endtask

    task automatic test_reset_mid();
        int pushed = 0;
        PopReady = 1'b0;
        for (int k = 0; k < 60 && pushed < 6; k++) begin
            PushValid = 1'b1; PushData = DW'($urandom);
            advance();
            if (s_pf) pushed++;
        end
        PushValid = 1'b0;
        repeat (3) advance();
        PopReady = 1'b1;
        advance();
        PopReady = 1'b0;
        #2;
        total++; if (Count !== 6'd5 || PopValid !== 1'b0) $display("FAIL midreset_pre count=%0d popvalid=%b exp 5/0", Count, PopValid); else passed++;
        Reset_n = 1'b0;
        #1;
        total++; if (PopValid !== 1'b0 || Count !== 6'd0 || Full !== 1'b0 || Empty !== 1'b1)
            $display("FAIL midreset_async popvalid=%b count=%0d full=%b empty=%b exp 0/0/0/1", PopValid, Count, Full, Empty); else passed++;
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        model.delete();
        PushValid = 1'b1; PushData = 8'd7; PopReady = 1'b1;
        for (int k = 0; k < 10; k++) begin
            advance();
            if (s_pf) break;
        end
        PushValid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            advance();
            if (s_qf) break;
        end
        total++; if (!s_qf || s_got !== 8'd7 || s_got !== s_exp) $display("FAIL midreset_first_pop pop=%b got=%0d exp=7", s_qf, s_got); else passed++;
    endtask

    initial begin
        Reset_n = 1'b0; PushValid = 1'b0; PushData = '0; PopReady = 1'b0;
        test_reset();
        test_latency();
        test_fill();
        test_drain();
        test_random_stream();
        test_contention();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
